// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard controller and its forwarding unit
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    function automatic logic is_link(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_JAL) || (opcode == OP_RTYPE && funct == FN_JALR);
    endfunction

endpackage

// File: rtl/hazard_ctrl_param_fwd_unit.sv
// fwd_unit: EX operand forwarding selects; MEM beats WB, $zero never forwards
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wr_en_mem,
    input  logic              wr_en_wb,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    logic mem_ok;
    logic wb_ok;

    assign mem_ok = wr_en_mem && (mem_rd != '0);
    assign wb_ok  = wr_en_wb && (wb_rd != '0);

    assign fwd_a_sel = (mem_ok && mem_rd == ex_rs) ? FWD_EXMEM :
                       (wb_ok && wb_rd == ex_rs)   ? FWD_MEMWB : FWD_RF;
    assign fwd_b_sel = (mem_ok && mem_rd == ex_rt) ? FWD_EXMEM :
                       (wb_ok && wb_rd == ex_rt)   ? FWD_MEMWB : FWD_RF;

endmodule

// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: load-use / link-drain stall FSM, branch flush and stall counter
// for the 5-stage MIPS pipeline; forwarding selects come from fwd_unit.
module hazard_ctrl_param
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       id_instr,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              wr_en_ex,
    input  logic              wr_en_mem,
    input  logic              wr_en_wb,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              branch_taken,
    input  logic              cnt_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              ctrl_en,
    output logic              if_id_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [1:0]        state_o
);

    state_e           state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             live_q;
    logic             load_hz;
    logic             link_id;
    logic             wr_pend;
    logic             stall;
    logic             flush;
    logic             unused_instr;

    assign unused_instr = ^id_instr[25:6];

    assign load_hz = ex_is_load && wr_en_ex && (ex_rd != '0) &&
                     ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    assign link_id = is_link(id_instr[31:26], id_instr[5:0]);
    assign wr_pend = wr_en_ex || wr_en_mem || wr_en_wb;

    // live_q holds the outputs at their idle values through reset and the release cycle
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        stall   = 1'b0;
        flush   = 1'b0;
        if (!live_q) begin
            state_d = RUN;
        end else if (branch_taken) begin
            flush   = 1'b1;
            state_d = RUN;
            bub_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_hz) begin
                        stall   = 1'b1;
                        bub_d   = 3'(LOAD_LAT - 1);
                        state_d = (LOAD_LAT > 1) ? LSTALL : RUN;
                    end else if (link_id && wr_pend) begin
                        stall   = 1'b1;
                        state_d = DRAIN;
                    end
                end
                LSTALL: begin
                    stall   = 1'b1;
                    bub_d   = bub_q - 3'd1;
                    state_d = (bub_q <= 3'd1) ? RUN : LSTALL;
                end
                DRAIN: begin
                    stall   = wr_pend;
                    state_d = wr_pend ? DRAIN : RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign cnt_d = cnt_clr            ? '0 :
                   (stall && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            bub_q   <= '0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    assign pc_en        = ~stall;
    assign if_id_en     = ~stall;
    assign ctrl_en      = ~stall & ~flush;
    assign if_id_flush  = flush;
    assign stall_cycles = cnt_q;
    assign state_o      = state_q;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .ex_rs     (ex_rs),
        .ex_rt     (ex_rt),
        .mem_rd    (mem_rd),
        .wb_rd     (wb_rd),
        .wr_en_mem (wr_en_mem),
        .wr_en_wb  (wr_en_wb),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel)
    );

endmodule
